// File: rtl/win_buzzer_ctrl.sv
// win_buzzer_ctrl: turns a rising edge of the registered win flag (Buzz) into
// a fixed beep pattern on the piezo buzzer, then pulses stop to freeze play,
// then waits for the win flag to clear before re-arming. Also keeps a
// saturating tally of celebrated wins for the display.
//
// Handshake: there is no valid/ready pair here. Buzz is a level; only its
// 0->1 edge (against win_q) starts a sequence, and only while IDLE. stop is
// a fixed-length pulse with no acknowledge. Every output is registered.
module win_buzzer_ctrl #(
  parameter int TONE_HALF = 113636,
  parameter int BEEP_LEN  = 25000000,
  parameter int GAP_LEN   = 12500000,
  parameter int NUM_BEEPS = 3,
  parameter int STOP_LEN  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Buzz,
  output logic       buzzer_out,
  output logic       stop,
  output logic       busy,
  output logic [7:0] win_count
);

  // One phase counter is shared by BEEP, GAP and HOLD, so it is sized for
  // the longest of the three.
  localparam int LEN_MAX_A = (BEEP_LEN > GAP_LEN) ? BEEP_LEN : GAP_LEN;
  localparam int LEN_MAX   = (LEN_MAX_A > STOP_LEN) ? LEN_MAX_A : STOP_LEN;
  localparam int CNT_W     = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;
  localparam int TONE_W    = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam int IDX_W     = $clog2(NUM_BEEPS + 1);

  localparam logic [CNT_W-1:0]  BEEP_LAST = CNT_W'(BEEP_LEN - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_LEN - 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
  localparam logic [IDX_W-1:0]  NUM_B     = IDX_W'(NUM_BEEPS);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BEEP       = 3'd1,
    GAP        = 3'd2,
    HOLD       = 3'd3,
    WAIT_CLEAR = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [TONE_W-1:0]   tone, tone_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic                win_q;
  logic                trig;
  logic                buz_n, stop_n, busy_n;
  logic [7:0]          win_n;

  // A fresh rising edge of the win flag; win_q resets to 1 so a flag already
  // high at reset release is not mistaken for a new win.
  assign trig = Buzz & ~win_q;

  // State, counters and all outputs are registered here; reset wins over
  // every transition.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      tone       <= '0;
      idx        <= '0;
      win_q      <= 1'b1;
      buzzer_out <= 1'b0;
      stop       <= 1'b0;
      busy       <= 1'b0;
      win_count  <= 8'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      tone       <= tone_n;
      idx        <= idx_n;
      win_q      <= Buzz;
      buzzer_out <= buz_n;
      stop       <= stop_n;
      busy       <= busy_n;
      win_count  <= win_n;
    end
  end

  // Next-state, next-counter and next-output logic for the beep sequence.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tone_n  = tone;
    idx_n   = idx;
    buz_n   = 1'b0;
    win_n   = win_count;

    case (state)
      IDLE: begin
        if (trig) begin
          state_n = BEEP;
          cnt_n   = '0;
          tone_n  = '0;
          idx_n   = IDX_W'(1);
          buz_n   = 1'b1;
          if (win_count != 8'hFF) win_n = win_count + 8'd1;
        end
      end

      BEEP: begin
        // Square wave: hold the level for TONE_HALF cycles, then flip.
        buz_n = buzzer_out;
        if (tone == TONE_LAST) begin
          tone_n = '0;
          buz_n  = ~buzzer_out;
        end else begin
          tone_n = tone + TONE_W'(1);
        end
        if (cnt == BEEP_LAST) begin
          cnt_n   = '0;
          tone_n  = '0;
          buz_n   = 1'b0;
          state_n = (idx < NUM_B) ? GAP : HOLD;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          tone_n  = '0;
          idx_n   = idx + IDX_W'(1);
          buz_n   = 1'b1;
          state_n = BEEP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      HOLD: begin
        if (cnt == STOP_LAST) begin
          cnt_n   = '0;
          state_n = WAIT_CLEAR;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      WAIT_CLEAR: begin
        if (!Buzz) state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        tone_n  = '0;
        idx_n   = '0;
      end
    endcase
  end

  // stop and busy are decoded from the next state so they line up with it.
  always_comb begin
    stop_n = (state_n == HOLD);
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_win_buzzer_ctrl.sv
// Directed bench for win_buzzer_ctrl using small timing parameters.
// Outputs are sampled 1 ns after each rising clock edge; inputs are changed
// at the same point so they are stable well before the next edge.
module tb_win_buzzer_ctrl;

  localparam int TONE_HALF = 2;
  localparam int BEEP_LEN  = 8;
  localparam int GAP_LEN   = 4;
  localparam int NUM_BEEPS = 2;
  localparam int STOP_LEN  = 3;
  localparam int SEQ_LEN   = 23;  // beep + gap + beep + hold cycles

  logic       clk;
  logic       reset_n;
  logic       Buzz;
  logic       buzzer_out;
  logic       stop;
  logic       busy;
  logic [7:0] win_count;

  int tests_run;
  int tests_failed;

  // Hand-derived per-cycle expectations, index 0 = first cycle after the
  // Buzz rising edge is sampled.
  logic exp_buz  [SEQ_LEN] = '{1,1,0,0,1,1,0,0, 0,0,0,0, 1,1,0,0,1,1,0,0, 0,0,0};
  logic exp_stop [SEQ_LEN] = '{0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0, 1,1,1};

  win_buzzer_ctrl #(
    .TONE_HALF(TONE_HALF),
    .BEEP_LEN (BEEP_LEN),
    .GAP_LEN  (GAP_LEN),
    .NUM_BEEPS(NUM_BEEPS),
    .STOP_LEN (STOP_LEN)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Buzz      (Buzz),
    .buzzer_out(buzzer_out),
    .stop      (stop),
    .busy      (busy),
    .win_count (win_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full checked sequence from IDLE with Buzz low. glitch drops Buzz for one
  // cycle inside the first beep, which must change nothing.
  task automatic run_seq(input string tag, input bit glitch, input logic [7:0] exp_cnt);
    Buzz = 1'b1;
    for (int i = 0; i < SEQ_LEN; i++) begin
      tick();
      chk({tag, "_buz"},  {7'd0, buzzer_out}, {7'd0, exp_buz[i]});
      chk({tag, "_stop"}, {7'd0, stop},       {7'd0, exp_stop[i]});
      chk({tag, "_busy"}, {7'd0, busy},       8'd1);
      if (glitch && i == 2) Buzz = 1'b0;
      if (glitch && i == 3) Buzz = 1'b1;
    end
    chk({tag, "_count"}, win_count, exp_cnt);
    // Buzz still high: parked in WAIT_CLEAR.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_wc_busy"}, {7'd0, busy},       8'd1);
      chk({tag, "_wc_stop"}, {7'd0, stop},       8'd0);
      chk({tag, "_wc_buz"},  {7'd0, buzzer_out}, 8'd0);
    end
    Buzz = 1'b0;
    tick();
    chk({tag, "_rearm_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_rearm_count"}, win_count, exp_cnt);
    tick();
  endtask

  // Unchecked full sequence used to drive the tally up quickly.
  task automatic fast_seq();
    Buzz = 1'b1;
    repeat (SEQ_LEN + 1) tick();
    Buzz = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    Buzz         = 1'b1;

    // Reset with the win flag already high.
    repeat (3) tick();
    chk("rst_buz",   {7'd0, buzzer_out}, 8'd0);
    chk("rst_stop",  {7'd0, stop},       8'd0);
    chk("rst_busy",  {7'd0, busy},       8'd0);
    chk("rst_count", win_count,          8'd0);

    // Release with Buzz held: no fresh edge, so nothing happens.
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_buz",   {7'd0, buzzer_out}, 8'd0);
      chk("hold_busy",  {7'd0, busy},       8'd0);
      chk("hold_count", win_count,          8'd0);
    end
    Buzz = 1'b0;
    repeat (2) tick();

    // Normal win, then a second win after re-arm, then a glitched one.
    run_seq("seq1", 1'b0, 8'd1);
    tick();
    run_seq("seq2", 1'b0, 8'd2);
    run_seq("glitch", 1'b1, 8'd3);

    // Reset during the gap kills the sequence; no stop pulse afterwards.
    Buzz = 1'b1;
    repeat (10) tick();
    chk("pre_rst_busy", {7'd0, busy}, 8'd1);
    reset_n = 1'b0;
    tick();
    chk("midrst_buz",   {7'd0, buzzer_out}, 8'd0);
    chk("midrst_stop",  {7'd0, stop},       8'd0);
    chk("midrst_busy",  {7'd0, busy},       8'd0);
    chk("midrst_count", win_count,          8'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      chk("postrst_stop", {7'd0, stop}, 8'd0);
      chk("postrst_busy", {7'd0, busy}, 8'd0);
    end
    Buzz = 1'b0;
    repeat (2) tick();

    // Saturating tally.
    for (int n = 1; n <= 260; n++) begin
      fast_seq();
      if (n == 1)   chk("sat_1",   win_count, 8'd1);
      if (n == 254) chk("sat_254", win_count, 8'd254);
      if (n == 255) chk("sat_255", win_count, 8'd255);
      if (n == 256) chk("sat_256", win_count, 8'd255);
    end
    chk("sat_260", win_count, 8'd255);
    chk("sat_idle_busy", {7'd0, busy}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/win_buzzer_ctrl.md
Name: win_buzzer_ctrl

Overview:
Consumes the registered win flag (Buzz) produced by the game's win-check logic and drives the board buzzer with a fixed beep pattern. At the end of the pattern it returns the stop pulse to the win-check logic and the game core, freezing play. It then re-arms only after the win flag clears, so one win gives exactly one celebration. It also keeps a saturating win tally for the display.

Parameters:
TONE_HALF, 113636, clk cycles per buzzer half-period (440 Hz at 100 MHz); minimum 1
BEEP_LEN, 25000000, clk cycles per beep (tone on); minimum 1
GAP_LEN, 12500000, clk cycles of silence between beeps; minimum 1
NUM_BEEPS, 3, beeps per win, 1..15
STOP_LEN, 4, clk cycles stop is held high; minimum 1

Ports:
clk  input  1  system clock, single clock domain
reset_n  input  1  synchronous, active-low reset
Buzz  input  1  win flag from the win-check logic; level, synchronous to clk
buzzer_out  output  1  square-wave drive to the piezo buzzer
stop  output  1  freeze/clear request back to the win-check logic and game core
busy  output  1  high whenever the FSM is not in IDLE
win_count  output  8  number of wins celebrated since reset, saturating

Behaviour:
- Reset: while reset_n=0 at a clk edge, the following take these values:
  - state=IDLE; buzzer_out=0, stop=0, busy=0, win_count=0; all counters=0.
  - win_q (previous-Buzz register) is set to 1, so a Buzz held high through reset does not trigger. A fresh 0→1 edge is required.
- Edge detect: trig = Buzz & ~win_q. win_q <= Buzz every cycle outside reset.
- All outputs are registered.
- IDLE:
  - On trig: go to BEEP, clear the beep counter, clear the tone counter, load beep index=1, increment win_count (hold at 255).
  - buzzer_out=1 on the first BEEP cycle. Latency is 1 clk from the Buzz rising edge.
- BEEP, lasts exactly BEEP_LEN cycles:
  - The tone counter counts 0..TONE_HALF-1. buzzer_out toggles when it wraps.
  - The waveform starts high and gives high/low runs of TONE_HALF cycles.
  - After BEEP_LEN cycles: if beep index < NUM_BEEPS, go to GAP; otherwise go to HOLD.
- GAP:
  - buzzer_out=0 for exactly GAP_LEN cycles.
  - Then go to BEEP: increment beep index, reset the tone phase (buzzer_out=1 on the first cycle).
- HOLD:
  - stop=1 for exactly STOP_LEN cycles, buzzer_out=0.
  - Then go to WAIT_CLEAR.
- WAIT_CLEAR:
  - stop=0, buzzer_out=0.
  - Go to IDLE on the first cycle Buzz=0. If Buzz is already 0, IDLE follows after one WAIT_CLEAR cycle.
- buzzer_out is forced 0 in every state except BEEP. busy=1 in BEEP, GAP, HOLD and WAIT_CLEAR.
- Buzz changing during BEEP, GAP or HOLD is ignored. The sequence always runs to completion once started. A Buzz drop and re-rise during the sequence does not restart it or add to win_count.
- Buzz 0→1 in the same cycle the FSM enters IDLE from WAIT_CLEAR:
  - Not possible as a trigger, because WAIT_CLEAR exit requires Buzz=0.
  - A rise on the first IDLE cycle does trigger normally.
- Reset asserted mid-sequence: next edge forces IDLE with all outputs 0. It takes priority over every transition.
- win_count stays at 255 once reached; wrap to 0 is forbidden.
- Counter widths use $clog2 of the largest count they must hold.
- No combinational path from Buzz to any output.

Test Plan:
Use small parameters: TONE_HALF=2, BEEP_LEN=8, GAP_LEN=4, NUM_BEEPS=2, STOP_LEN=3.
- Reset with Buzz=1, release reset_n, hold Buzz=1 for 20 cycles → buzzer_out=0, busy=0, win_count=0 throughout (no trigger without a fresh edge).
- Buzz 0→1 at cycle T → buzzer_out pattern is 1,1,0,0,1,1,0,0 (T+1..T+8), then 0 for 4 cycles, then 1,1,0,0,1,1,0,0 again. stop=1 for cycles T+21..T+23. busy=1 from T+1. win_count=1.
- Keep Buzz=1 after HOLD → FSM stays in WAIT_CLEAR with busy=1, stop=0. Drop Buzz at cycle U → busy=0 at U+1. A new rise at U+3 starts a second sequence and win_count=2.
- Pulse Buzz low then high mid-first-beep → pattern and timing are identical to the second scenario. win_count increments only once.
- Assert reset_n=0 for 1 cycle during GAP → next cycle buzzer_out=0, stop=0, busy=0, win_count=0. No stop pulse follows.
- Force 260 complete win sequences → win_count reads 255 and stays there.
